// File: rtl/dma_bus_master_pkg.sv
// Shared definitions for the DMA bus master: FSM state encodings, DSACK_ codes
// and a small decode helper for the acknowledge lines.
package dma_bus_master_pkg;

  // Bus-cycle sequencer states; IDLE must encode as zero.
  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ADDR     = 3'd1,
    ST_STROBE   = 3'd2,
    ST_WAIT_ACK = 3'd3,
    ST_TERM     = 3'd4,
    ST_RECOVER  = 3'd5
  } state_e;

  // DSACK_ codes as seen after synchronization (active-low lines).
  localparam logic [1:0] DSACK_32   = 2'b00;
  localparam logic [1:0] DSACK_NONE = 2'b11;

  // True when the target answered as an 8- or 16-bit port; these are not supported.
  function automatic logic dsack_is_narrow(input logic [1:0] ack);
    return (ack == 2'b01) || (ack == 2'b10);
  endfunction

endpackage

// File: rtl/dma_bus_master_bus_sync.sv
// Two-flop synchronizer for asynchronous bus handshake inputs. Resets to the
// negated (all-ones) level so no spurious acknowledge appears after reset.
module bus_sync #(
  parameter int WIDTH = 1
) (
  input  logic             CLK,
  input  logic             RESET_,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_r;
  logic [WIDTH-1:0] sync_r;

  // Two-stage resynchronization into the CLK domain.
  always_ff @(posedge CLK) begin
    if (!RESET_) begin
      meta_r <= {WIDTH{1'b1}};
      sync_r <= {WIDTH{1'b1}};
    end else begin
      meta_r <= d;
      sync_r <= meta_r;
    end
  end

  assign q = sync_r;

endmodule

// File: rtl/dma_bus_master.sv
// Initiator side of the 68030 asynchronous bus for SDMAC DMA transfers.
// Runs one longword cycle per START: drives AS_/DS_/R_W, waits for DSACK_ or
// BERR_ (or a timeout), captures read data and pulses DONE or ERR.
// Strobe/enable outputs are registered decodes of the state being left, so
// each pin changes one edge after the FSM enters the corresponding state.
module dma_bus_master
  import dma_bus_master_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        CLK,
  input  logic        RESET_,
  input  logic        START,
  input  logic        RW,
  input  logic [31:0] ADDR_IN,
  input  logic [31:0] WDATA,
  input  logic [1:0]  DSACK_,
  input  logic        BERR_,
  input  logic [31:0] DATA_IN,
  output logic [31:0] ADDR_O,
  output logic [31:0] DATA_O,
  output logic        DOE,
  output logic        AS_O_,
  output logic        DS_O_,
  output logic        R_W_O,
  output logic        OWN,
  output logic [31:0] RDATA,
  output logic        BUSY,
  output logic        DONE,
  output logic        ERR
);

  // Last counter value spent in WAIT_ACK: the state lasts exactly TIMEOUT_CYCLES cycles.
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_e      state_r,   state_nxt_s;
  logic        rw_r,      rw_nxt_s;
  logic [31:0] addr_r,    addr_nxt_s;
  logic [31:0] wdata_r,   wdata_nxt_s;
  logic [31:0] rdata_r,   rdata_nxt_s;
  logic [7:0]  cnt_r,     cnt_nxt_s;
  logic        ok_r,      ok_nxt_s;
  logic        as_r,      as_nxt_s;
  logic        ds_r,      ds_nxt_s;
  logic        r_w_r,     r_w_nxt_s;
  logic        doe_r,     doe_nxt_s;
  logic        own_r,     own_nxt_s;
  logic        busy_r,    busy_nxt_s;
  logic        done_r,    done_nxt_s;
  logic        err_r,     err_nxt_s;

  logic [2:0]  sync_s;
  logic [1:0]  ack_s;
  logic        berr_s;

  bus_sync #(.WIDTH(3)) u_bus_sync (
    .CLK    (CLK),
    .RESET_ (RESET_),
    .d      ({BERR_, DSACK_}),
    .q      (sync_s)
  );

  assign berr_s = sync_s[2];
  assign ack_s  = sync_s[1:0];

  // Next-state and next-output decode for the bus-cycle sequencer.
  always_comb begin
    state_nxt_s = state_r;
    rw_nxt_s    = rw_r;
    addr_nxt_s  = addr_r;
    wdata_nxt_s = wdata_r;
    rdata_nxt_s = rdata_r;
    cnt_nxt_s   = cnt_r;
    ok_nxt_s    = ok_r;
    as_nxt_s    = as_r;
    ds_nxt_s    = ds_r;
    r_w_nxt_s   = r_w_r;
    doe_nxt_s   = doe_r;
    own_nxt_s   = own_r;
    busy_nxt_s  = busy_r;
    done_nxt_s  = 1'b0;
    err_nxt_s   = 1'b0;

    case (state_r)
      ST_IDLE: begin
        if (START) begin
          state_nxt_s = ST_ADDR;
          rw_nxt_s    = RW;
          addr_nxt_s  = ADDR_IN;
          wdata_nxt_s = WDATA;
          busy_nxt_s  = 1'b1;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end

      ST_ADDR: begin
        own_nxt_s   = 1'b1;
        as_nxt_s    = 1'b0;
        r_w_nxt_s   = rw_r;
        doe_nxt_s   = ~rw_r;
        state_nxt_s = ST_STROBE;
      end

      ST_STROBE: begin
        ds_nxt_s    = 1'b0;
        cnt_nxt_s   = 8'd0;
        state_nxt_s = ST_WAIT_ACK;
      end

      ST_WAIT_ACK: begin
        // Bus error outranks any acknowledge seen in the same sample.
        if (!berr_s) begin
          ok_nxt_s    = 1'b0;
          state_nxt_s = ST_TERM;
        end else if (ack_s == DSACK_32) begin
          ok_nxt_s    = 1'b1;
          state_nxt_s = ST_TERM;
          if (rw_r) begin
            rdata_nxt_s = DATA_IN;
          end else begin
            rdata_nxt_s = rdata_r;
          end
        end else if (dsack_is_narrow(ack_s)) begin
          ok_nxt_s    = 1'b0;
          state_nxt_s = ST_TERM;
        end else if (cnt_r == TIMEOUT_LAST) begin
          ok_nxt_s    = 1'b0;
          state_nxt_s = ST_TERM;
        end else begin
          cnt_nxt_s   = cnt_r + 8'd1;
          state_nxt_s = ST_WAIT_ACK;
        end
      end

      ST_TERM: begin
        as_nxt_s    = 1'b1;
        ds_nxt_s    = 1'b1;
        doe_nxt_s   = 1'b0;
        done_nxt_s  = ok_r;
        err_nxt_s   = ~ok_r;
        state_nxt_s = ST_RECOVER;
      end

      ST_RECOVER: begin
        // Keep the bus until the target has fully released its handshake lines.
        if ((ack_s == DSACK_NONE) && berr_s) begin
          own_nxt_s   = 1'b0;
          busy_nxt_s  = 1'b0;
          r_w_nxt_s   = 1'b1;
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_RECOVER;
        end
      end

      default: begin
        as_nxt_s    = 1'b1;
        ds_nxt_s    = 1'b1;
        doe_nxt_s   = 1'b0;
        own_nxt_s   = 1'b0;
        busy_nxt_s  = 1'b0;
        r_w_nxt_s   = 1'b1;
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State, datapath latches and registered bus outputs.
  always_ff @(posedge CLK) begin
    if (!RESET_) begin
      state_r <= ST_IDLE;
      rw_r    <= 1'b1;
      addr_r  <= 32'd0;
      wdata_r <= 32'd0;
      rdata_r <= 32'd0;
      cnt_r   <= 8'd0;
      ok_r    <= 1'b0;
      as_r    <= 1'b1;
      ds_r    <= 1'b1;
      r_w_r   <= 1'b1;
      doe_r   <= 1'b0;
      own_r   <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      err_r   <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      rw_r    <= rw_nxt_s;
      addr_r  <= addr_nxt_s;
      wdata_r <= wdata_nxt_s;
      rdata_r <= rdata_nxt_s;
      cnt_r   <= cnt_nxt_s;
      ok_r    <= ok_nxt_s;
      as_r    <= as_nxt_s;
      ds_r    <= ds_nxt_s;
      r_w_r   <= r_w_nxt_s;
      doe_r   <= doe_nxt_s;
      own_r   <= own_nxt_s;
      busy_r  <= busy_nxt_s;
      done_r  <= done_nxt_s;
      err_r   <= err_nxt_s;
    end
  end

  assign ADDR_O = addr_r;
  assign DATA_O = wdata_r;
  assign DOE    = doe_r;
  assign AS_O_  = as_r;
  assign DS_O_  = ds_r;
  assign R_W_O  = r_w_r;
  assign OWN    = own_r;
  assign RDATA  = rdata_r;
  assign BUSY   = busy_r;
  assign DONE   = done_r;
  assign ERR    = err_r;

endmodule
